// File: rtl/bcd_to_bin.sv
// Iterative packed-BCD to binary converter (reverse double-dabble).
// One shift-and-correct iteration per clock; start/busy/done handshake.
module bcd_to_bin #(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_WIDTH-1:0]  bin_out
);

  localparam int BW = 4 * DIGITS;
  localparam int TW = BW + BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [BW-1:0]        bcd_reg;
  logic [BIN_WIDTH-1:0] bin_reg;
  logic [CW-1:0]        cnt;

  logic [TW-1:0]        sh;
  logic [BW-1:0]        bcd_nx;
  logic                 bad;

  // a nibble >= 8 is exactly one with its MSB set
  always_comb begin
    sh     = {bcd_reg, bin_reg} >> 1;
    bcd_nx = sh[TW-1:BIN_WIDTH];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_nx[4*i+3]) begin
        bcd_nx[4*i +: 4] = bcd_nx[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err <= bad;
            if (bad) begin
              bin_out <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              cnt     <= CW'(BIN_WIDTH);
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_nx;
          bin_reg <= sh[BIN_WIDTH-1:0];
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bin_out <= sh[BIN_WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: latency, handshake, errors,
// ignored starts, reset abort and back-to-back conversions.
module tb_bcd_to_bin;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [13:0] bin_out;

  int checks = 0;
  int errors = 0;
  logic [13:0] last_bin;

  bcd_to_bin #(
    .DIGITS   (4),
    .BIN_WIDTH(14)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bin_out(bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start at a negedge; cycle n is the negedge after sampling edge n
  task automatic conv(input string tag, input logic [15:0] v,
                      input logic [13:0] eb, input logic ee,
                      input int elat, input int pulse_at);
    int n;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'hffff;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_hold"}, bin_out, last_bin);
      if (n == 1) chk({tag, "_errclr"}, err, 0);
      start  = (n == pulse_at);
      bcd_in = (n == pulse_at) ? 16'h0001 : 16'hffff;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_bin"}, bin_out, eb);
    chk({tag, "_err"}, err, ee);
    last_bin = eb;
  endtask

  initial begin
    logic seen;
    rst    = 1'b1;
    start  = 1'b1;
    bcd_in = 16'h0123;
    last_bin = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bin", bin_out, 0);
    rst   = 1'b0;
    start = 1'b0;

    conv("zero", 16'h0000, 14'h0000, 1'b0, 15, 0);
    conv("d1023", 16'h1023, 14'h03ff, 1'b0, 15, 0);
    @(negedge clk);
    chk("d1023_width", done, 0);

    conv("d9999", 16'h9999, 14'h270f, 1'b0, 15, 0);
    conv("d0042_b2b", 16'h0042, 14'h002a, 1'b0, 15, 0);

    conv("bad12a4", 16'h12a4, 14'h0000, 1'b1, 1, 0);
    @(negedge clk);
    chk("bad_width", done, 0);
    chk("bad_errhold", err, 1);
    conv("d0005", 16'h0005, 14'h0005, 1'b0, 15, 0);

    conv("d0500_ign", 16'h0500, 14'h01f4, 1'b0, 15, 3);
    @(negedge clk);
    chk("ign_idle_busy", busy, 0);

    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0777;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bin", bin_out, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort_nodone", seen, 0);
    last_bin = '0;
    conv("d0777", 16'h0777, 14'h0309, 1'b0, 15, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Iterative BCD-to-binary converter using reverse double-dabble: shift right one bit per clock, then subtract 3 from any BCD nibble that is >= 8.
- It is the inverse of the binary-to-BCD display path.
- It converts packed decimal digits (keypad/calculator entry) into a binary operand for the arithmetic unit.
- Uses a start/busy/done handshake, one conversion at a time.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in.
- BIN_WIDTH, 14, output width and number of shift iterations.
  - Must satisfy 2^BIN_WIDTH > 10^DIGITS - 1.
  - The default covers 0..9999.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled on the accepted start edge only.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse: result or error is valid.
- err  output  1  set if any input nibble > 9; held until the next accepted start.
- bin_out  output  BIN_WIDTH  binary result; held until the next accepted start.

Behaviour:
- Reset: a synchronous rst=1 forces
  - state=IDLE, busy=0, done=0, err=0, bin_out=0;
  - internal shift register=0, iteration counter=0.
  - rst overrides start in the same cycle.
- Internal register: {bcd_reg[4*DIGITS-1:0], bin_reg[BIN_WIDTH-1:0]}.
- States:
  - IDLE:
    - On start=1, clear err.
    - If any nibble of bcd_in > 9:
      - set err=1, load bin_out=0, go to DONE.
    - Otherwise:
      - load bcd_reg=bcd_in, bin_reg=0, counter=BIN_WIDTH;
      - go to SHIFT, busy=1.
    - If start=0, stay in IDLE.
  - SHIFT: each cycle performs one iteration.
    - Shift the concatenation right by 1; the bcd_reg LSB enters the bin_reg MSB, and 0 enters the bcd_reg MSB.
    - Then, on the shifted value, each nibble of bcd_reg that is >= 8 has 3 subtracted.
    - Decrement counter. The iteration that brings counter to 0 moves the state to DONE and copies the final bin_reg to bin_out.
  - DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency, measured from the clock edge that samples start:
  - Valid input: busy is high for BIN_WIDTH cycles. done is high in cycle BIN_WIDTH+1 (15 cycles for the default).
  - Invalid input: done is high in the cycle after start (no shifting).
- start while busy or while done=1 is ignored; bcd_in changes during SHIFT have no effect.
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted.
  - Minimum period is BIN_WIDTH+2 cycles.
- bin_out only updates on successful completion, or is cleared to 0 on error. It is never partially updated during SHIFT.
- Reset mid-SHIFT aborts the conversion: no done pulse, bin_out=0.
- Arithmetic: nibble correction uses 4-bit subtract. A nibble >= 8 minus 3 never underflows, and valid input never yields a nibble > 12 after the shift.
- At completion, bcd_reg is all zero for valid input. Implementations may assert this in simulation only.

Test Plan:
- Reset, then bcd_in=0x0000 with start pulse -> done in cycle 15, bin_out=0, err=0; busy high cycles 1..14.
- bcd_in=0x1023 -> bin_out=0x03FF (1023), err=0, done pulse exactly 1 cycle wide.
- bcd_in=0x9999 -> bin_out=0x270F; then immediate start with 0x0042 in the first IDLE cycle -> bin_out=0x002A.
  - bin_out must hold 0x270F until the second done.
- bcd_in=0x12A4 (invalid nibble) -> done in cycle 1 after start, err=1, bin_out=0.
  - A following valid 0x0005 clears err, giving bin_out=5.
- Start with 0x0500; at cycle 3 pulse start with bcd_in=0x0001 -> ignored, final bin_out=500 (0x01F4).
- Start with 0x0777; assert rst at cycle 7 -> no done, busy=0, bin_out=0 next cycle.
  - A subsequent start with 0x0777 -> 0x0309.
